streaming_avg_pool2d: RTL and testbench

//  Streaming, channel-parallel 2-D average pool with non-overlapping windows (kernel = stride = IN/OUT per axis).

---
 rtl/streaming_avg_pool2d_if.sv | 23 ++
 rtl/streaming_avg_pool2d.sv | 130 +++++++++++++
 tb/tb_streaming_avg_pool2d.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/streaming_avg_pool2d_if.sv
// Pixel-stream bus for the average pool: one input beat channel and one output beat channel,
// both valid/ready handshaked.
interface streaming_avg_pool2d_if #(
    parameter int unsigned P        = 8,
    parameter int unsigned CHANNELS = 4
) ();
    logic [CHANNELS-1:0][P-1:0] data_in_0;
    logic                       data_in_0_valid;
    logic                       data_in_0_ready;
    logic [CHANNELS-1:0][P-1:0] data_out_0;
    logic                       data_out_0_valid;
    logic                       data_out_0_ready;

    modport slave (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid
    );

    modport master (
        output data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid
    );
endinterface

// File: rtl/streaming_avg_pool2d.sv
// Streaming, channel-parallel 2-D average pool with non-overlapping windows.
// Raster-order pixels in, one rounded and saturated average per completed window out.
module streaming_avg_pool2d #(
    parameter int unsigned DATA_IN_0_PRECISION_0  = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1  = 3,
    parameter int unsigned DATA_OUT_0_PRECISION_0 = 8,
    parameter int unsigned DATA_OUT_0_PRECISION_1 = 3,
    parameter int unsigned DATA_IN_0_WIDTH        = 8,
    parameter int unsigned DATA_IN_0_HEIGHT       = 8,
    parameter int unsigned DATA_OUT_0_WIDTH       = 2,
    parameter int unsigned DATA_OUT_0_HEIGHT      = 2,
    parameter int unsigned CHANNELS               = 4,
    parameter int unsigned RECIP_FRAC             = 16
) (
    input logic                    clk,
    input logic                    rst,
    streaming_avg_pool2d_if.slave  bus
);
    localparam int unsigned P      = DATA_IN_0_PRECISION_0;
    localparam int unsigned OW     = DATA_OUT_0_WIDTH;
    localparam int unsigned KW     = DATA_IN_0_WIDTH / DATA_OUT_0_WIDTH;
    localparam int unsigned KH     = DATA_IN_0_HEIGHT / DATA_OUT_0_HEIGHT;
    localparam int unsigned N      = KH * KW;
    localparam int unsigned ACC_W  = P + $clog2(N);
    localparam int unsigned PROD_W = ACC_W + RECIP_FRAC + 2;
    localparam int unsigned KW_W   = (KW > 1) ? $clog2(KW) : 1;
    localparam int unsigned KH_W   = (KH > 1) ? $clog2(KH) : 1;
    localparam int unsigned OW_W   = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned RECIP  = ((1 << RECIP_FRAC) + N / 2) / N;

    localparam logic signed [PROD_W-1:0] RECIP_S = PROD_W'(RECIP);
    localparam logic signed [PROD_W-1:0] ROUND_S = (RECIP_FRAC == 0) ? '0 : PROD_W'(1 << (RECIP_FRAC - 1));
    localparam logic signed [PROD_W-1:0] MAX_S   = PROD_W'((1 << (P - 1)) - 1);
    localparam logic signed [PROD_W-1:0] MIN_S   = -PROD_W'(1 << (P - 1));

    if ((KW * DATA_OUT_0_WIDTH != DATA_IN_0_WIDTH) || (KH * DATA_OUT_0_HEIGHT != DATA_IN_0_HEIGHT)) begin : g_bad_div
        $error("input dimensions must be divisible by output dimensions");
    end
    if ((DATA_IN_0_PRECISION_0 != DATA_OUT_0_PRECISION_0) || (DATA_IN_0_PRECISION_1 != DATA_OUT_0_PRECISION_1)) begin : g_bad_prec
        $error("input and output precisions must match");
    end
    if ((N == 1) && (RECIP_FRAC == 0)) begin : g_bad_recip
        $error("RECIP_FRAC must be non-zero for a 1x1 window");
    end

    logic [KW_W-1:0] kw_cnt;
    logic [OW_W-1:0] ow_cnt;
    logic [KH_W-1:0] kh_cnt;
    logic            fire_in;
    logic            first_c;
    logic            last_c;
    logic [CHANNELS-1:0][P-1:0] avg_c;

    assign bus.data_in_0_ready = !bus.data_out_0_valid || bus.data_out_0_ready;
    assign fire_in = bus.data_in_0_valid && bus.data_in_0_ready;
    assign first_c = (kw_cnt == '0) && (kh_cnt == '0);
    assign last_c  = (kw_cnt == KW_W'(KW - 1)) && (kh_cnt == KH_W'(KH - 1));

    // Raster position as kernel-column / output-column / kernel-row counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kw_cnt <= '0;
            ow_cnt <= '0;
            kh_cnt <= '0;
        end else if (fire_in) begin
            if (kw_cnt == KW_W'(KW - 1)) begin
                kw_cnt <= '0;
                if (ow_cnt == OW_W'(OW - 1)) begin
                    ow_cnt <= '0;
                    kh_cnt <= (kh_cnt == KH_W'(KH - 1)) ? '0 : kh_cnt + KH_W'(1);
                end else begin
                    ow_cnt <= ow_cnt + OW_W'(1);
                end
            end else begin
                kw_cnt <= kw_cnt + KW_W'(1);
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [ACC_W-1:0]  acc [OW];
        logic signed [P-1:0]      x_s;
        logic signed [ACC_W-1:0]  base;
        logic signed [ACC_W-1:0]  sum;
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shifted;
        logic        [P-1:0]      avg;

        // Running window sum, then reciprocal multiply with round-half-up and saturation.
        always_comb begin
            x_s  = bus.data_in_0[c];
            base = '0;
            if (!first_c) begin
                base = acc[ow_cnt];
            end
            sum     = base + ACC_W'(x_s);
            prod    = PROD_W'(sum) * RECIP_S + ROUND_S;
            shifted = prod >>> RECIP_FRAC;
            if (shifted > MAX_S) begin
                avg = P'(MAX_S);
            end else if (shifted < MIN_S) begin
                avg = P'(MIN_S);
            end else begin
                avg = P'(shifted);
            end
        end

        // Partial sums are scratch storage; the first beat of each window overwrites them.
        always_ff @(posedge clk) begin
            if (fire_in) begin
                acc[ow_cnt] <= sum;
            end
        end

        assign avg_c[c] = avg;
    end

    // Single-entry output register; a completing beat may refill it in the same cycle it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_out_0_valid <= 1'b0;
            bus.data_out_0       <= '0;
        end else if (fire_in && last_c) begin
            bus.data_out_0_valid <= 1'b1;
            bus.data_out_0       <= avg_c;
        end else if (bus.data_out_0_ready) begin
            bus.data_out_0_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_streaming_avg_pool2d.sv
// Self-checking bench: a 4x4->2x2 four-channel pool and a 6x6->2x2 (3x3 kernel) single-channel pool,
// each checked against a scoreboard filled from an exact round-half-up model.
module tb_streaming_avg_pool2d;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    streaming_avg_pool2d_if #(.P(8), .CHANNELS(4)) a_if ();
    streaming_avg_pool2d_if #(.P(8), .CHANNELS(1)) b_if ();

    streaming_avg_pool2d #(
        .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(3),
        .DATA_IN_0_WIDTH(4), .DATA_IN_0_HEIGHT(4),
        .DATA_OUT_0_WIDTH(2), .DATA_OUT_0_HEIGHT(2),
        .CHANNELS(4), .RECIP_FRAC(16)
    ) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));

    streaming_avg_pool2d #(
        .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(3),
        .DATA_IN_0_WIDTH(6), .DATA_IN_0_HEIGHT(6),
        .DATA_OUT_0_WIDTH(2), .DATA_OUT_0_HEIGHT(2),
        .CHANNELS(1), .RECIP_FRAC(16)
    ) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0][7:0] q_a[$];
    logic [7:0]      q_b[$];
    int frame_a [4][4][4];
    int frame_b [6][6];

    bit   stall_mode  = 1'b0;
    bit   chk_latency = 1'b0;
    int   cyc         = 0;
    bit   a_prev_stall = 1'b0;
    logic [3:0][7:0] a_prev_data;
    logic [3:0][7:0] a_exp;
    logic [7:0]      b_exp;

    function automatic logic [7:0] exp_avg(input int sum, input int n);
        int num, den, q;
        num = 2 * sum + n;
        den = 2 * n;
        q   = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    // Downstream ready pattern for the stall test: high one cycle in three.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (stall_mode) begin
            #1 a_if.data_out_0_ready = ((cyc % 3) == 0);
        end
    end

    // Output monitor for the 4x4 pool: scoreboard, hold-while-stalled, ready rule.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_if.data_out_0_valid && a_if.data_out_0_ready) begin
                n_tests++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_unexpected_output got=%h expected=none", a_if.data_out_0);
                end else begin
                    a_exp = q_a.pop_front();
                    if (a_if.data_out_0 !== a_exp) begin
                        n_fail++;
                        $display("FAIL a_output got=%h expected=%h", a_if.data_out_0, a_exp);
                    end
                end
            end
            if (a_prev_stall) begin
                n_tests++;
                if (a_if.data_out_0_valid !== 1'b1 || a_if.data_out_0 !== a_prev_data) begin
                    n_fail++;
                    $display("FAIL a_hold got=%b/%h expected=1/%h", a_if.data_out_0_valid, a_if.data_out_0, a_prev_data);
                end
            end
            if (!a_if.data_in_0_ready) begin
                n_tests++;
                if (!(a_if.data_out_0_valid && !a_if.data_out_0_ready)) begin
                    n_fail++;
                    $display("FAIL a_ready_low got=0 expected=1 (out_valid=%b out_ready=%b)", a_if.data_out_0_valid, a_if.data_out_0_ready);
                end
            end
            a_prev_stall = a_if.data_out_0_valid && !a_if.data_out_0_ready;
            a_prev_data  = a_if.data_out_0;
        end else begin
            a_prev_stall = 1'b0;
        end
    end

    // Output monitor for the 3x3-kernel pool.
    always @(negedge clk) begin
        if (!rst && b_if.data_out_0_valid && b_if.data_out_0_ready) begin
            n_tests++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected_output got=%0d expected=none", $signed(b_if.data_out_0[0]));
            end else begin
                b_exp = q_b.pop_front();
                if (b_if.data_out_0[0] !== b_exp) begin
                    n_fail++;
                    $display("FAIL b_output got=%0d expected=%0d", $signed(b_if.data_out_0[0]), $signed(b_exp));
                end
            end
        end
    end

    task automatic drive_a_beat(input int r, input int col, input bit gaps);
        logic [3:0][7:0] exp;
        bit last;
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        for (int c = 0; c < 4; c++) a_if.data_in_0[c] = 8'(frame_a[c][r][col]);
        a_if.data_in_0_valid = 1'b1;
        last = ((r % 2) == 1) && ((col % 2) == 1);
        exp  = '0;
        if (last) begin
            for (int c = 0; c < 4; c++)
                exp[c] = exp_avg(frame_a[c][r-1][col-1] + frame_a[c][r-1][col] +
                                 frame_a[c][r][col-1] + frame_a[c][r][col], 4);
            q_a.push_back(exp);
        end
        t = 0;
        forever begin
            @(negedge clk);
            if (a_if.data_in_0_ready) break;
            t++;
            if (t > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_input_timeout got=ready0 expected=ready1 at r=%0d c=%0d", r, col);
                a_if.data_in_0_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        a_if.data_in_0_valid = 1'b0;
        if (chk_latency) begin
            n_tests++;
            if (last && (a_if.data_out_0_valid !== 1'b1 || a_if.data_out_0 !== exp)) begin
                n_fail++;
                $display("FAIL a_latency got=%b/%h expected=1/%h", a_if.data_out_0_valid, a_if.data_out_0, exp);
            end else if (!last && a_if.data_out_0_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL a_idle_valid got=%b expected=0 at r=%0d c=%0d", a_if.data_out_0_valid, r, col);
            end
        end
    endtask

    task automatic drive_frame_a(input int n_beats, input bit gaps);
        for (int i = 0; i < n_beats; i++) drive_a_beat(i / 4, i % 4, gaps);
    endtask

    task automatic wait_drain_a(input string name);
        int t = 0;
        while (q_a.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (q_a.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain got=%0d pending expected=0", name, q_a.size());
        end
    endtask

    task automatic set_ramp_a(input int ch_step);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int col = 0; col < 4; col++)
                    frame_a[c][r][col] = r * 4 + col + ch_step * c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_if.data_in_0_valid  = 1'b0;
        a_if.data_in_0        = '0;
        a_if.data_out_0_ready = 1'b1;
        b_if.data_in_0_valid  = 1'b0;
        b_if.data_in_0        = '0;
        b_if.data_out_0_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (a_if.data_out_0_valid !== 1'b0 || a_if.data_out_0 !== '0) begin
            n_fail++;
            $display("FAIL reset_a_out got=%b/%h expected=0/0", a_if.data_out_0_valid, a_if.data_out_0);
        end
        n_tests++;
        if (a_if.data_in_0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_a_ready got=%b expected=1", a_if.data_in_0_ready);
        end
        n_tests++;
        if (b_if.data_out_0_valid !== 1'b0 || b_if.data_out_0 !== '0) begin
            n_fail++;
            $display("FAIL reset_b_out got=%b/%h expected=0/0", b_if.data_out_0_valid, b_if.data_out_0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_raster();
        set_ramp_a(0);
        chk_latency = 1'b1;
        drive_frame_a(16, 1'b0);
        chk_latency = 1'b0;
        wait_drain_a("raster");
    endtask

    task automatic test_negative_round();
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int col = 0; col < 4; col++)
                    frame_a[c][r][col] = (((r % 2) == 1) && ((col % 2) == 1)) ? -2 : -3;
        drive_frame_a(16, 1'b0);
        wait_drain_a("neg_round");
    endtask

    task automatic test_stall();
        set_ramp_a(0);
        stall_mode = 1'b1;
        drive_frame_a(16, 1'b1);
        wait_drain_a("stall");
        stall_mode = 1'b0;
        @(posedge clk);
        #2;
        a_if.data_out_0_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_channels();
        set_ramp_a(16);
        drive_frame_a(16, 1'b0);
        wait_drain_a("channels");
    endtask

    task automatic test_mid_reset();
        set_ramp_a(0);
        drive_frame_a(6, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (a_if.data_out_0_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_valid got=%b expected=0", a_if.data_out_0_valid);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (a_if.data_out_0_valid !== 1'b0 || q_a.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_state got=%b/%0d expected=0/0", a_if.data_out_0_valid, q_a.size());
        end
        chk_latency = 1'b1;
        drive_frame_a(16, 1'b0);
        chk_latency = 1'b0;
        wait_drain_a("mid_reset");
    endtask

    task automatic drive_b_beat(input int r, input int col);
        int t = 0;
        int sum;
        b_if.data_in_0[0]    = 8'(frame_b[r][col]);
        b_if.data_in_0_valid = 1'b1;
        if ((r % 3) == 2 && (col % 3) == 2) begin
            sum = 0;
            for (int kr = 0; kr < 3; kr++)
                for (int kc = 0; kc < 3; kc++)
                    sum += frame_b[r-2+kr][col-2+kc];
            q_b.push_back(exp_avg(sum, 9));
        end
        forever begin
            @(negedge clk);
            if (b_if.data_in_0_ready) break;
            t++;
            if (t > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_input_timeout got=ready0 expected=ready1");
                b_if.data_in_0_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        b_if.data_in_0_valid = 1'b0;
    endtask

    task automatic test_kernel3();
        int t = 0;
        for (int r = 0; r < 6; r++)
            for (int col = 0; col < 6; col++) begin
                if (r < 3 && col < 3)      frame_b[r][col] = (r == 1 && col == 1) ? 5 : 1;
                else if (r < 3)            frame_b[r][col] = 127;
                else if (col < 3)          frame_b[r][col] = -128;
                else                       frame_b[r][col] = (r == 5 && col == 5) ? -1 : 2;
            end
        for (int i = 0; i < 36; i++) drive_b_beat(i / 6, i % 6);
        while (q_b.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        n_tests++;
        if (q_b.size() != 0) begin
            n_fail++;
            $display("FAIL kernel3_drain got=%0d pending expected=0", q_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_negative_round();
        test_stall();
        test_channels();
        test_mid_reset();
        test_kernel3();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
